// File: rtl/maindec_mc.sv
// maindec_mc: multicycle main decoder FSM for a small ARMv8 subset.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and emits the datapath
// controls for each step. Memory accesses wait on mem_ready.
// Optional feature macro MAINDEC_MC_EXC_EN adds exceptions: an EXC state, ERET
// decoding, fetch/memory bus timeouts after MAX_WAIT wait cycles, external
// interrupts sampled on the first FETCH cycle, and the EStatus cause register.
// Without the macro, undecodable opcodes simply retire and memory waits are
// unbounded.
// Handshake: mem_ready is the memory's acknowledge for the access the FSM is
// currently requesting (instruction fetch in FETCH, data access in MEM); a
// cycle with mem_ready=1 completes that access, and any cycle without it is a
// wait cycle.
module maindec_mc #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        mem_ready,
  input  logic        ExtIRQ,
  output logic        Reg2Loc,
  output logic [1:0]  ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        ERet,
  output logic [1:0]  ALUOp,
  output logic [3:0]  EStatus,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Exc,
  output logic        Retire,
  output logic [2:0]  state_dbg
);

  localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OP_CBZ  = 11'b101_1010_0000;
  localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OP_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OP_ORR  = 11'b101_0101_0000;
  localparam logic [10:0] OP_ERET = 11'b110_1011_0100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
`ifdef MAINDEC_MC_EXC_EN
    S_WB     = 3'd4,
    S_EXC    = 3'd5
`else
    S_WB     = 3'd4
`endif
  } state_t;

  state_t      state, next_state;
  logic [10:0] op_q;
  logic [7:0]  wait_cnt;
  logic        wait_hit;

  // raw (ungated) controls from the FSM
  logic       reg2loc_c, memtoreg_c, regwrite_c, memread_c, memwrite_c;
  logic       branch_c, irwrite_c, pcwrite_c, retire_c;
  logic [1:0] alusrc_c, aluop_c;

  logic dec_ldst, dec_rtype;
  logic op_ld, op_st, op_rtype;

`ifdef MAINDEC_MC_EXC_EN
  logic       eret_c, exc_c, estat_clr, exc_take;
  logic [3:0] exc_cause;
  logic [3:0] estatus_q;
  logic       first_fetch;
`else
  logic       unused_irq;
  assign unused_irq = ExtIRQ;
`endif

  // this wait cycle would be the MAX_WAIT-th without an acknowledge
  assign wait_hit = (({1'b0, wait_cnt} + 9'd1) == 9'(MAX_WAIT));

  // opcode classes: Op is examined in DECODE, the latched op_q afterwards
  assign dec_ldst  = (Op == OP_LDUR) || (Op == OP_STUR);
  assign dec_rtype = (Op == OP_ADD) || (Op == OP_SUB) || (Op == OP_AND) || (Op == OP_ORR);
  assign op_ld     = (op_q == OP_LDUR);
  assign op_st     = (op_q == OP_STUR);
  assign op_rtype  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_ORR);

  assign state_dbg = state;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // next-state logic and raw controls
  always_comb begin
    next_state = state;
    reg2loc_c  = 1'b0;
    alusrc_c   = 2'b00;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    branch_c   = 1'b0;
    aluop_c    = 2'b00;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    retire_c   = 1'b0;
`ifdef MAINDEC_MC_EXC_EN
    eret_c     = 1'b0;
    exc_c      = 1'b0;
    estat_clr  = 1'b0;
    exc_take   = 1'b0;
    exc_cause  = 4'b0000;
`endif
    unique case (state)
      S_FETCH: begin
`ifdef MAINDEC_MC_EXC_EN
        if (first_fetch && ExtIRQ) begin
          next_state = S_EXC;
          exc_take   = 1'b1;
          exc_cause  = 4'b0001;
        end else
`endif
        if (mem_ready) begin
          irwrite_c  = 1'b1;
          pcwrite_c  = 1'b1;
          next_state = S_DECODE;
        end
`ifdef MAINDEC_MC_EXC_EN
        else if (wait_hit) begin
          next_state = S_EXC;
          exc_take   = 1'b1;
          exc_cause  = 4'b0100;
        end
`endif
      end
      S_DECODE: begin
`ifdef MAINDEC_MC_EXC_EN
        if (dec_ldst || dec_rtype || (Op == OP_CBZ) || (Op == OP_ERET)) begin
          next_state = S_EXEC;
        end else begin
          next_state = S_EXC;
          exc_take   = 1'b1;
          exc_cause  = 4'b0010;
        end
`else
        if (dec_ldst || dec_rtype || (Op == OP_CBZ)) begin
          next_state = S_EXEC;
        end else begin
          retire_c   = 1'b1;
          next_state = S_FETCH;
        end
`endif
      end
      S_EXEC: begin
        if (op_ld || op_st) begin
          reg2loc_c  = op_st;
          alusrc_c   = 2'b01;
          next_state = S_MEM;
        end else if (op_rtype) begin
          aluop_c    = 2'b10;
          next_state = S_WB;
        end else if (op_q == OP_CBZ) begin
          reg2loc_c  = 1'b1;
          branch_c   = 1'b1;
          aluop_c    = 2'b01;
          retire_c   = 1'b1;
          next_state = S_FETCH;
        end
`ifdef MAINDEC_MC_EXC_EN
        else if (op_q == OP_ERET) begin
          eret_c     = 1'b1;
          pcwrite_c  = 1'b1;
          retire_c   = 1'b1;
          estat_clr  = 1'b1;
          next_state = S_FETCH;
        end
`endif
        else begin
          next_state = S_FETCH;
        end
      end
      S_MEM: begin
        // ALU controls from EXEC stay up while the data access is pending
        reg2loc_c  = op_st;
        alusrc_c   = 2'b01;
        memread_c  = op_ld;
        memwrite_c = op_st;
        if (mem_ready) begin
          retire_c   = op_st;
          next_state = op_st ? S_FETCH : S_WB;
        end
`ifdef MAINDEC_MC_EXC_EN
        else if (wait_hit) begin
          next_state = S_EXC;
          exc_take   = 1'b1;
          exc_cause  = 4'b0100;
        end
`endif
      end
      S_WB: begin
        regwrite_c = 1'b1;
        memtoreg_c = op_ld;
        retire_c   = 1'b1;
        next_state = S_FETCH;
      end
`ifdef MAINDEC_MC_EXC_EN
      S_EXC: begin
        exc_c      = 1'b1;
        pcwrite_c  = 1'b1;
        next_state = S_FETCH;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  // outputs are forced low for as long as reset is held
  always_comb begin
    Reg2Loc  = reg2loc_c & ~reset;
    ALUSrc   = alusrc_c & {2{~reset}};
    MemtoReg = memtoreg_c & ~reset;
    RegWrite = regwrite_c & ~reset;
    MemRead  = memread_c & ~reset;
    MemWrite = memwrite_c & ~reset;
    Branch   = branch_c & ~reset;
    ALUOp    = aluop_c & {2{~reset}};
    IRWrite  = irwrite_c & ~reset;
    PCWrite  = pcwrite_c & ~reset;
    Retire   = retire_c & ~reset;
`ifdef MAINDEC_MC_EXC_EN
    ERet     = eret_c & ~reset;
    Exc      = exc_c & ~reset;
    EStatus  = estatus_q;
`else
    ERet     = 1'b0;
    Exc      = 1'b0;
    EStatus  = 4'b0000;
`endif
  end

  // wait counter: restarts on every state change, counts cycles without mem_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     wait_cnt <= 8'd0;
    else if (next_state != state)  wait_cnt <= 8'd0;
    else if (!mem_ready && !wait_hit) wait_cnt <= wait_cnt + 8'd1;
  end

  // op register captured in DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  op_q <= 11'd0;
    else if (state == S_DECODE) op_q <= Op;
  end

`ifdef MAINDEC_MC_EXC_EN
  // the counter is still zero only on the first cycle spent in FETCH
  assign first_fetch = (wait_cnt == 8'd0);

  // exception cause register: loaded when an exception is taken, cleared by ERET
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          estatus_q <= 4'b0000;
    else if (exc_take)  estatus_q <= exc_cause;
    else if (estat_clr) estatus_q <= 4'b0000;
  end
`endif

endmodule
